// File: rtl/vga_axil_regfile.sv
// vga_axil_regfile: parametrised AXI4-Lite slave register file with per-byte
// strobes, read-only status registers, independent AW/W acceptance and SLVERR.
module vga_axil_regfile #(
    parameter int unsigned         ADDR_WIDTH = 32,
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ADDR_WIDTH-1:0]          awaddr_i,
    input  logic                           awvalid_i,
    output logic                           awready_o,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
    input  logic                           wvalid_i,
    output logic                           wready_o,
    output logic [1:0]                     bresp_o,
    output logic                           bvalid_o,
    input  logic                           bready_i,
    input  logic [ADDR_WIDTH-1:0]          araddr_i,
    input  logic                           arvalid_i,
    output logic                           arready_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [1:0]                     rresp_o,
    output logic                           rvalid_o,
    input  logic                           rready_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFFSET = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_WIDTH - OFFSET;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_aw_held;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic                  r_w_held;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [STRB_W-1:0]     r_w_strb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [NUM_REGS-1:0]   r_wr_pulse;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [STRB_W-1:0]     w_wstrb;
    logic [IDX_W-1:0]      w_widx;
    logic [IDX_W-1:0]      w_ridx;
    logic [NUM_REGS-1:0]   w_wsel;
    logic [NUM_REGS-1:0]   w_rsel;
    logic                  w_wok;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_lsbs;

    assign awready_o  = !r_aw_held && !r_bvalid;
    assign wready_o   = !r_w_held && !r_bvalid;
    assign arready_o  = !r_rvalid;
    assign bvalid_o   = r_bvalid;
    assign bresp_o    = r_bresp;
    assign rvalid_o   = r_rvalid;
    assign rdata_o    = r_rdata;
    assign rresp_o    = r_rresp;
    assign wr_pulse_o = r_wr_pulse;

    assign w_aw_hs  = awvalid_i && awready_o;
    assign w_w_hs   = wvalid_i && wready_o;
    assign w_ar_hs  = arvalid_i && arready_o;
    // A held slot or a same-cycle handshake both count as available.
    assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_waddr  = r_aw_held ? r_aw_addr : awaddr_i;
    assign w_wdata  = r_w_held ? r_w_data : wdata_i;
    assign w_wstrb  = r_w_held ? r_w_strb : wstrb_i;
    assign w_widx   = w_waddr[ADDR_WIDTH-1:OFFSET];
    assign w_ridx   = araddr_i[ADDR_WIDTH-1:OFFSET];
    assign w_wok    = |(w_wsel & ~RO_MASK);

    // Sub-word address bits carry no meaning; accesses act as aligned.
    assign w_unused_lsbs = ^{w_waddr[OFFSET-1:0], araddr_i[OFFSET-1:0]};

    // Decode write/read indices into one-hot selects; out-of-range gives zero.
    always_comb begin
        w_wsel = '0;
        w_rsel = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_widx == IDX_W'(i)) w_wsel[i] = 1'b1;
            if (w_ridx == IDX_W'(i)) w_rsel[i] = 1'b1;
        end
    end

    // Read mux: RO registers return live status, RW return stored value.
    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_rsel[i]) begin
                w_rdata = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
            end
        end
    end

    // Flatten the register array onto regs_o.
    always_comb begin
        regs_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
        end
    end

    // Write path: AW/W holding slots, commit with byte strobes, B response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_aw_held  <= 1'b0;
            r_aw_addr  <= '0;
            r_w_held   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_aw_held  <= 1'b0;
                r_w_held   <= 1'b0;
                r_bvalid   <= 1'b1;
                r_bresp    <= w_wok ? OKAY : SLVERR;
                r_wr_pulse <= w_wsel & ~RO_MASK;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (w_wsel[i] && !RO_MASK[i]) begin
                        for (int unsigned b = 0; b < STRB_W; b++) begin
                            if (w_wstrb[b]) r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
                        end
                    end
                end
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= awaddr_i;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= wdata_i;
                    r_w_strb <= wstrb_i;
                end
                if (r_bvalid && bready_i) r_bvalid <= 1'b0;
            end
        end
    end

    // Read path: latch data/response on AR handshake, hold until R handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
            r_rresp  <= (|w_rsel) ? OKAY : SLVERR;
        end else if (r_rvalid && rready_i) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_axil_regfile.sv
// tb_vga_axil_regfile: directed self-checking bench for vga_axil_regfile.
module tb_vga_axil_regfile;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  awaddr_i;
    logic         awvalid_i;
    logic         awready_o;
    logic [31:0]  wdata_i;
    logic [3:0]   wstrb_i;
    logic         wvalid_i;
    logic         wready_o;
    logic [1:0]   bresp_o;
    logic         bvalid_o;
    logic         bready_i;
    logic [31:0]  araddr_i;
    logic         arvalid_i;
    logic         arready_o;
    logic [31:0]  rdata_o;
    logic [1:0]   rresp_o;
    logic         rvalid_o;
    logic         rready_i;
    logic [255:0] regs_o;
    logic [7:0]   wr_pulse_o;
    logic [255:0] status_i;

    int unsigned  n_total = 0;
    int unsigned  n_pass  = 0;
    logic [31:0]  exp_regs [8];

    vga_axil_regfile #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (8),
        .RO_MASK    (8'b0000_0100)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .awaddr_i   (awaddr_i),
        .awvalid_i  (awvalid_i),
        .awready_o  (awready_o),
        .wdata_i    (wdata_i),
        .wstrb_i    (wstrb_i),
        .wvalid_i   (wvalid_i),
        .wready_o   (wready_o),
        .bresp_o    (bresp_o),
        .bvalid_o   (bvalid_o),
        .bready_i   (bready_i),
        .araddr_i   (araddr_i),
        .arvalid_i  (arvalid_i),
        .arready_o  (arready_o),
        .rdata_o    (rdata_o),
        .rresp_o    (rresp_o),
        .rvalid_o   (rvalid_o),
        .rready_i   (rready_i),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o),
        .status_i   (status_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 8; i++) chk(tag, 64'(regs_o[i*32 +: 32]), 64'(exp_regs[i]));
    endtask

    // Simultaneous AW+W, check commit cycle, then complete B.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] resp, input logic [7:0] pulse);
        awaddr_i = addr; awvalid_i = 1'b1;
        wdata_i  = data; wstrb_i   = strb; wvalid_i = 1'b1;
        tick();
        awvalid_i = 1'b0; wvalid_i = 1'b0;
        chk("wr_bvalid", 64'(bvalid_o), 64'd1);
        chk("wr_bresp", 64'(bresp_o), 64'(resp));
        chk("wr_pulse", 64'(wr_pulse_o), 64'(pulse));
        chk_regs("wr_regs");
        bready_i = 1'b1;
        tick();
        bready_i = 1'b0;
        chk("wr_bdone", 64'(bvalid_o), 64'd0);
        chk("wr_pulse_clr", 64'(wr_pulse_o), 64'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        araddr_i = addr; arvalid_i = 1'b1;
        tick();
        arvalid_i = 1'b0;
        chk("rd_rvalid", 64'(rvalid_o), 64'd1);
        chk("rd_rdata", 64'(rdata_o), 64'(data));
        chk("rd_rresp", 64'(rresp_o), 64'(resp));
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        chk("rd_rdone", 64'(rvalid_o), 64'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        awaddr_i = '0; awvalid_i = 1'b0; wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0;
        bready_i = 1'b0; araddr_i = '0; arvalid_i = 1'b0; rready_i = 1'b0;
        status_i = '0;
        status_i[2*32 +: 32] = 32'hCAFE_0002;
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;

        // Reset state
        tick(); tick();
        chk("rst_awready", 64'(awready_o), 64'd1);
        chk("rst_wready", 64'(wready_o), 64'd1);
        chk("rst_arready", 64'(arready_o), 64'd1);
        chk("rst_bvalid", 64'(bvalid_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_pulse", 64'(wr_pulse_o), 64'd0);
        chk_regs("rst_regs");
        rst_i = 1'b0;
        tick();

        // Full write then read, B backpressure covered separately below
        exp_regs[1] = 32'hDEAD_BEEF;
        do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 2'b00, 8'h02);
        chk("aw_ready_after_b", 64'(awready_o), 64'd1);

        // Read with R backpressure for 5 cycles
        araddr_i = 32'h4; arvalid_i = 1'b1;
        tick();
        arvalid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rvalid", 64'(rvalid_o), 64'd1);
            chk("bp_rdata", 64'(rdata_o), 64'hDEAD_BEEF);
            chk("bp_rresp", 64'(rresp_o), 64'd0);
            chk("bp_arready", 64'(arready_o), 64'd0);
            tick();
        end
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        chk("bp_rdone", 64'(rvalid_o), 64'd0);
        chk("bp_arready_back", 64'(arready_o), 64'd1);

        // Split channels: W three cycles before AW, byte strobes 0x5
        wdata_i = 32'h1122_3344; wstrb_i = 4'h5; wvalid_i = 1'b1;
        tick();
        wvalid_i = 1'b0;
        chk("split_wready", 64'(wready_o), 64'd0);
        chk("split_awready", 64'(awready_o), 64'd1);
        tick();
        chk("split_nobvalid", 64'(bvalid_o), 64'd0);
        tick();
        chk("split_nopulse", 64'(wr_pulse_o), 64'd0);
        awaddr_i = 32'h4; awvalid_i = 1'b1;
        tick();
        awvalid_i = 1'b0;
        exp_regs[1] = 32'hDE22_BE44;
        chk("split_bvalid", 64'(bvalid_o), 64'd1);
        chk("split_pulse", 64'(wr_pulse_o), 64'h02);
        chk_regs("split_regs");
        // B backpressure for 5 cycles
        for (int k = 0; k < 5; k++) begin
            chk("bp_bvalid", 64'(bvalid_o), 64'd1);
            chk("bp_bresp", 64'(bresp_o), 64'd0);
            chk("bp_awready", 64'(awready_o), 64'd0);
            chk("bp_wready", 64'(wready_o), 64'd0);
            tick();
            chk("bp_single_pulse", 64'(wr_pulse_o), 64'd0);
        end
        bready_i = 1'b1;
        tick();
        bready_i = 1'b0;
        chk("split_bdone", 64'(bvalid_o), 64'd0);

        // Unaligned read acts as aligned
        do_read(32'h7, 32'hDE22_BE44, 2'b00);

        // Error cases
        do_write(32'h20, 32'hFFFF_FFFF, 4'hF, 2'b10, 8'h00);
        do_write(32'h8, 32'h1234_5678, 4'hF, 2'b10, 8'h00);
        do_read(32'h20, 32'h0, 2'b10);
        do_read(32'h8, 32'hCAFE_0002, 2'b00);
        status_i[2*32 +: 32] = 32'h0BAD_F00D;
        do_read(32'h8, 32'h0BAD_F00D, 2'b00);

        // Same-cycle read and write to reg0: read returns old value
        exp_regs[0] = 32'h0000_00AA;
        do_write(32'h0, 32'h0000_00AA, 4'hF, 2'b00, 8'h01);
        awaddr_i = 32'h0; awvalid_i = 1'b1;
        wdata_i = 32'h0000_0055; wstrb_i = 4'hF; wvalid_i = 1'b1;
        araddr_i = 32'h0; arvalid_i = 1'b1;
        tick();
        awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
        exp_regs[0] = 32'h0000_0055;
        chk("conc_rdata", 64'(rdata_o), 64'h0000_00AA);
        chk("conc_pulse", 64'(wr_pulse_o), 64'h01);
        chk("conc_bvalid", 64'(bvalid_o), 64'd1);
        chk_regs("conc_regs");
        bready_i = 1'b1; rready_i = 1'b1;
        tick();
        bready_i = 1'b0; rready_i = 1'b0;

        // Reset mid-transaction with B and R pending
        awaddr_i = 32'hC; awvalid_i = 1'b1;
        wdata_i = 32'h1234_5678; wvalid_i = 1'b1;
        araddr_i = 32'h4; arvalid_i = 1'b1;
        tick();
        awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
        chk("mid_bvalid", 64'(bvalid_o), 64'd1);
        chk("mid_rvalid", 64'(rvalid_o), 64'd1);
        rst_i = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;
        chk("arst_bvalid", 64'(bvalid_o), 64'd0);
        chk("arst_rvalid", 64'(rvalid_o), 64'd0);
        chk("arst_rdata", 64'(rdata_o), 64'd0);
        chk("arst_pulse", 64'(wr_pulse_o), 64'd0);
        chk("arst_awready", 64'(awready_o), 64'd1);
        chk("arst_wready", 64'(wready_o), 64'd1);
        chk("arst_arready", 64'(arready_o), 64'd1);
        chk_regs("arst_regs");
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_nob", 64'(bvalid_o), 64'd0);
            chk("post_rst_nor", 64'(rvalid_o), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_axil_regfile.md
# vga_axil_regfile

Parametrised AXI4-Lite slave register file, the generic control/status front end for VGA IP blocks. Generalises the fixed 32-bit word-addressed AXI4-Lite conventions to configurable address width, data width and register count. Adds per-byte write strobes, read-only status registers, independent AW/W acceptance and SLVERR reporting. Sits between the system AXI4-Lite interconnect and the VGA timing/pixel logic, exposing registers as flat vectors.

## Interface
- ADDR_WIDTH, 32, AXI4-Lite address width.
- DATA_WIDTH, 32, data width: 32 or 64.
- NUM_REGS, 8, register count: 1..2^(ADDR_WIDTH-OFFSET), OFFSET = log2(DATA_WIDTH/8).
- RO_MASK, '0 (NUM_REGS bits), bit i = 1 makes register i read-only, sourced from status_i.
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- awaddr_i, awvalid_i / awready_o  AW channel: in ADDR_WIDTH, in 1 / out 1.
- wdata_i, wstrb_i, wvalid_i / wready_o  W channel: in DATA_WIDTH, in DATA_WIDTH/8, in 1 / out 1.
- bresp_o, bvalid_o / bready_i  B channel: out 2, out 1 / in 1.
- araddr_i, arvalid_i / arready_o  AR channel: in ADDR_WIDTH, in 1 / out 1.
- rdata_o, rresp_o, rvalid_o / rready_i  R channel: out DATA_WIDTH, out 2, out 1 / in 1.
- regs_o  out  NUM_REGS*DATA_WIDTH  register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse on each committed write to register i.
- status_i  in  NUM_REGS*DATA_WIDTH  read values for RO registers; ignored for RW registers.

## Operation
- Index = addr[ADDR_WIDTH-1:OFFSET]; low OFFSET bits ignored (unaligned accesses act as aligned).
- Responses: OKAY = 2'b00, SLVERR = 2'b10; no other codes.
- Write path: AW and W accepted independently into one-entry holding slots (aw_held, w_held).
  - awready_o = !aw_held && !bvalid_o; wready_o = !w_held && !bvalid_o.
  - Commit when both address and data are available (held or handshaking this cycle).
  - Commit with index < NUM_REGS and RO_MASK[index] = 0: bytes with wstrb set are updated, others kept, wr_pulse_o[index] = 1 for one cycle, bresp OKAY.
  - Commit with index >= NUM_REGS, or to an RO register: no state change, no pulse, bresp SLVERR.
  - Commit sets bvalid_o and clears both slots; bvalid_o holds until bready_i.
- Read path: arready_o = !rvalid_o. On AR handshake rdata_o/rresp_o are latched and rvalid_o set; held stable until rready_i.
  - RW register: rdata = stored value. RO register: rdata = status_i slice sampled at handshake. Out of range: rdata = 0, SLVERR.
- Read and write paths are fully independent and may handshake in the same cycle.

## Timing
- Reset (async assert, sync deassert by clock): registers, regs_o, wr_pulse_o, bvalid_o, rvalid_o, bresp_o, rresp_o, rdata_o = 0; slots empty, so awready_o = wready_o = arready_o = 1.
- Write latency: AW+W handshake in cycle N gives register value, wr_pulse_o and bvalid_o in cycle N+1.
- Split AW/W: commit in the cycle the later handshake completes; B in the following cycle.
- No new AW/W is accepted while bvalid_o = 1; B handshake in cycle M gives awready_o/wready_o = 1 in M+1 (max throughput one write per 2 cycles).
- Read latency: AR handshake in N gives rvalid_o in N+1; new AR accepted in the cycle after R handshake.
- Read and write to the same register in the same cycle: read returns the old value.
- Reset asserted mid-transaction: slots, pending B and R are discarded immediately; no response is issued after reset.

## Test plan
- Reset: assert rst_i mid-write with bvalid_o = 1 -> all outputs 0, readies 1, regs_o = 0 at once, no B after release.
- Full write/read: AW+W to 0x4 with 0xDEADBEEF, wstrb 0xF -> regs_o reg1 = 0xDEADBEEF and wr_pulse_o[1] in N+1, bresp OKAY; read 0x4 -> rdata 0xDEADBEEF, OKAY.
- Strobes, split channels: W (0x11223344, wstrb 0x5) three cycles before AW to 0x4 -> reg1 = 0xDE22BE44, single pulse, B one cycle after AW handshake.
- Errors: write to 0x20 (NUM_REGS=8) -> SLVERR, no regs_o change; write to RO reg2 -> SLVERR; read 0x20 -> rdata 0, SLVERR; read reg2 -> current status_i slice, OKAY.
- Backpressure: hold bready_i/rready_i low 5 cycles -> bvalid/rvalid, bresp/rdata stable, awready/wready/arready low throughout.
- Concurrency: write 0x55 and read reg0 (old 0xAA) in the same cycle -> rdata 0xAA, reg0 = 0x55 afterwards.
